// File: rtl/sram_lsu_pkg.sv
// Shared definitions for the SRAM load/store unit: access sizes, FSM states
// and the store-side lane steering helpers.
package sram_lsu_pkg;

  localparam logic [1:0] SIZE_BYTE    = 2'd0;
  localparam logic [1:0] SIZE_HALF    = 2'd1;
  localparam logic [1:0] SIZE_WORD    = 2'd2;
  localparam logic [1:0] SIZE_ILLEGAL = 2'd3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_CAPT = 2'd1,
    RESP    = 2'd2
  } state_t;

  function automatic logic [3:0] lane_byte_en(input logic [1:0] size, input logic [1:0] lane);
    logic [3:0] be;
    case (size)
      SIZE_BYTE: be = 4'b0001 << lane;
      SIZE_HALF: be = lane[1] ? 4'b1100 : 4'b0011;
      default:   be = 4'b1111;
    endcase
    return be;
  endfunction

  // Store data is replicated across lanes so the byte enables alone pick the target.
  function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [31:0] wdata);
    logic [31:0] wd;
    case (size)
      SIZE_BYTE: wd = {4{wdata[7:0]}};
      SIZE_HALF: wd = {2{wdata[15:0]}};
      default:   wd = wdata;
    endcase
    return wd;
  endfunction

endpackage

// File: rtl/sram_lsu_if.sv
// CPU request/response handshake plus the SRAM read/write port pair.
// master = requester side (CPU and attached SRAM), slave = the load/store unit.
interface sram_lsu_if #(
  parameter int LOGDEPTH = 10
);
  logic                req_valid;
  logic                req_ready;
  logic                req_write;
  logic [31:0]         req_addr;
  logic [1:0]          req_size;
  logic                req_unsigned;
  logic [31:0]         req_wdata;
  logic                resp_valid;
  logic                resp_ready;
  logic [31:0]         resp_rdata;
  logic                resp_err;
  logic                sram_read_req;
  logic [LOGDEPTH-1:0] sram_read_addr;
  logic [31:0]         sram_read_data;
  logic                sram_write_req;
  logic [LOGDEPTH-1:0] sram_write_addr;
  logic [3:0]          sram_write_byte_en;
  logic [31:0]         sram_write_data;

  modport master (
    output req_valid, req_write, req_addr, req_size, req_unsigned, req_wdata,
    output resp_ready, sram_read_data,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  sram_read_req, sram_read_addr, sram_write_req, sram_write_addr,
    input  sram_write_byte_en, sram_write_data
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_size, req_unsigned, req_wdata,
    input  resp_ready, sram_read_data,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output sram_read_req, sram_read_addr, sram_write_req, sram_write_addr,
    output sram_write_byte_en, sram_write_data
  );
endinterface

// File: rtl/sram_lsu_load_align.sv
// Combinational load alignment: selects the addressed byte/half of a word
// and sign- or zero-extends it to 32 bits.
module sram_lsu_load_align
  import sram_lsu_pkg::*;
(
  input  logic [31:0] data,
  input  logic [1:0]  lane,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  output logic [31:0] extended
);

  logic [7:0]  byte_lanes [4];
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign byte_lanes[gi] = data[8*gi +: 8];
  end

  assign byte_sel = byte_lanes[lane];
  assign half_sel = lane[1] ? data[31:16] : data[15:0];

  always_comb begin
    extended = data;
    case (size)
      SIZE_BYTE: extended = {{24{~is_unsigned & byte_sel[7]}}, byte_sel};
      SIZE_HALF: extended = {{16{~is_unsigned & half_sel[15]}}, half_sel};
      default:   extended = data;
    endcase
  end

endmodule

// File: rtl/sram_lsu.sv
// Load/store initiator: one CPU request at a time into a word SRAM with
// byte enables, with range/alignment checking and a registered response.
module sram_lsu
  import sram_lsu_pkg::*;
#(
  parameter int DEPTH = 1024
) (
  input logic      clk,
  input logic      reset,
  sram_lsu_if.slave bus
);

  localparam int LOGDEPTH = $clog2(DEPTH);

  state_t        state_reg, state_next;
  logic [1:0]    lane_reg, lane_next;
  logic [1:0]    size_reg, size_next;
  logic          unsigned_reg, unsigned_next;
  logic          resp_valid_reg, resp_valid_next;
  logic          resp_err_reg, resp_err_next;
  logic [31:0]   resp_rdata_reg, resp_rdata_next;

  logic [LOGDEPTH-1:0] word_idx;
  logic [1:0]          req_lane;
  logic                req_err;
  logic                read_strobe;
  logic                write_strobe;
  logic [31:0]         load_ext;

  assign word_idx = bus.req_addr[LOGDEPTH+1:2];
  assign req_lane = bus.req_addr[1:0];

  always_comb begin
    req_err = 1'b0;
    if (bus.req_size == SIZE_ILLEGAL)                      req_err = 1'b1;
    if (bus.req_size == SIZE_HALF && req_lane[0])          req_err = 1'b1;
    if (bus.req_size == SIZE_WORD && req_lane != 2'b00)    req_err = 1'b1;
    if (|bus.req_addr[31:LOGDEPTH+2])                      req_err = 1'b1;
  end

  sram_lsu_load_align u_load_align (
    .data        (bus.sram_read_data),
    .lane        (lane_reg),
    .size        (size_reg),
    .is_unsigned (unsigned_reg),
    .extended    (load_ext)
  );

  always_comb begin
    state_next      = state_reg;
    lane_next       = lane_reg;
    size_next       = size_reg;
    unsigned_next   = unsigned_reg;
    resp_valid_next = resp_valid_reg;
    resp_err_next   = resp_err_reg;
    resp_rdata_next = resp_rdata_reg;
    read_strobe     = 1'b0;
    write_strobe    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.req_valid) begin
          state_next      = RESP;
          resp_valid_next = 1'b1;
          resp_err_next   = req_err;
          resp_rdata_next = 32'd0;
          if (!req_err && bus.req_write) begin
            write_strobe = ~reset;
          end else if (!req_err) begin
            // Loads carry no response yet; decode info is kept for the capture cycle.
            read_strobe     = ~reset;
            state_next      = RD_CAPT;
            resp_valid_next = 1'b0;
            lane_next       = req_lane;
            size_next       = bus.req_size;
            unsigned_next   = bus.req_unsigned;
          end
        end
      end
      RD_CAPT: begin
        state_next      = RESP;
        resp_valid_next = 1'b1;
        resp_err_next   = 1'b0;
        resp_rdata_next = load_ext;
      end
      RESP: begin
        if (bus.resp_ready) begin
          state_next      = IDLE;
          resp_valid_next = 1'b0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      lane_reg       <= 2'd0;
      size_reg       <= SIZE_BYTE;
      unsigned_reg   <= 1'b0;
      resp_valid_reg <= 1'b0;
      resp_err_reg   <= 1'b0;
      resp_rdata_reg <= 32'd0;
    end else begin
      state_reg      <= state_next;
      lane_reg       <= lane_next;
      size_reg       <= size_next;
      unsigned_reg   <= unsigned_next;
      resp_valid_reg <= resp_valid_next;
      resp_err_reg   <= resp_err_next;
      resp_rdata_reg <= resp_rdata_next;
    end
  end

  assign bus.req_ready          = (state_reg == IDLE);
  assign bus.resp_valid         = resp_valid_reg;
  assign bus.resp_err           = resp_err_reg;
  assign bus.resp_rdata         = resp_rdata_reg;
  assign bus.sram_read_req      = read_strobe;
  assign bus.sram_read_addr     = word_idx;
  assign bus.sram_write_req     = write_strobe;
  assign bus.sram_write_addr    = word_idx;
  assign bus.sram_write_byte_en = lane_byte_en(bus.req_size, req_lane);
  assign bus.sram_write_data    = lane_wdata(bus.req_size, bus.req_wdata);

endmodule

// File: tb/tb_sram_lsu.sv
// Directed bench for sram_lsu with a behavioural 1024-word SRAM attached.
module tb_sram_lsu;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic preload = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  sram_lsu_if #(.LOGDEPTH(10)) bus ();

  sram_lsu #(.DEPTH(1024)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [31:0] mem [1024];

  always @(posedge clk) begin
    if (preload) begin
      mem[5] <= 32'h80FF7F01;
      mem[8] <= 32'h11223344;
      mem[9] <= 32'h55667788;
      bus.sram_read_data <= 32'd0;
    end else begin
      if (bus.sram_write_req) begin
        for (int b = 0; b < 4; b++)
          if (bus.sram_write_byte_en[b])
            mem[bus.sram_write_addr][8*b +: 8] <= bus.sram_write_data[8*b +: 8];
      end
      if (bus.sram_read_req)
        bus.sram_read_data <= mem[bus.sram_read_addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp_v);
    end
  endtask

  // Runs one request from a negedge; returns response and the strobes seen in the accept cycle.
  task automatic do_txn(input logic wr, input logic [31:0] addr, input logic [1:0] size,
                        input logic uns, input logic [31:0] wdata, input int hold,
                        output logic [31:0] rdata, output logic err, output int lat,
                        output logic rd_stb, output logic wr_stb,
                        output logic [3:0] be, output logic [31:0] wd);
    int budget;
    bus.req_valid    = 1'b1;
    bus.req_write    = wr;
    bus.req_addr     = addr;
    bus.req_size     = size;
    bus.req_unsigned = uns;
    bus.req_wdata    = wdata;
    budget = 0;
    while (!bus.req_ready && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    check("accept_wait", budget < 20 ? 32'd1 : 32'd0, 32'd1);
    #1;
    rd_stb = bus.sram_read_req;
    wr_stb = bus.sram_write_req;
    be     = bus.sram_write_byte_en;
    wd     = bus.sram_write_data;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    lat = 1;
    while (!bus.resp_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    rdata = bus.resp_rdata;
    err   = bus.resp_err;
    for (int i = 0; i < hold; i++) begin
      // A competing store offered while the response is held must be ignored.
      bus.req_valid = 1'b1;
      bus.req_write = 1'b1;
      bus.req_addr  = 32'h20;
      bus.req_size  = 2'd2;
      bus.req_wdata = 32'hDEADBEEF;
      @(negedge clk);
      check("hold_valid", bus.resp_valid, 1);
      check("hold_rdata", bus.resp_rdata, rdata);
      check("hold_req_ready", bus.req_ready, 0);
      check("hold_no_write", bus.sram_write_req, 0);
    end
    bus.req_valid  = 1'b0;
    bus.resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.resp_ready = 1'b0;
    check("resp_drop", bus.resp_valid, 0);
    check("ready_after", bus.req_ready, 1);
    $display("txn wr=%0d addr=%h size=%0d uns=%0d rdata=%h err=%0d lat=%0d", wr, addr, size, uns,
             rdata, err, lat);
  endtask

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic [3:0]  exp_be;
    logic [31:0] exp_wd;
  } vec_t;

  vec_t vecs [13];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rdata;
    logic        err;
    int          lat;
    logic        rd_stb, wr_stb;
    logic [3:0]  be;
    logic [31:0] wd;

    vecs[0]  = '{1'b0, 32'h17,   2'd0, 1'b0, 32'h0,        32'hFFFFFF80, 1'b0, 4'h0,    32'h0};
    vecs[1]  = '{1'b0, 32'h15,   2'd0, 1'b1, 32'h0,        32'h0000007F, 1'b0, 4'h0,    32'h0};
    vecs[2]  = '{1'b0, 32'h16,   2'd1, 1'b0, 32'h0,        32'hFFFF80FF, 1'b0, 4'h0,    32'h0};
    vecs[3]  = '{1'b0, 32'h14,   2'd2, 1'b0, 32'h0,        32'h80FF7F01, 1'b0, 4'h0,    32'h0};
    vecs[4]  = '{1'b0, 32'h14,   2'd1, 1'b1, 32'h0,        32'h00007F01, 1'b0, 4'h0,    32'h0};
    vecs[5]  = '{1'b1, 32'h22,   2'd0, 1'b0, 32'h123456AB, 32'h0,        1'b0, 4'b0100, 32'hABABABAB};
    vecs[6]  = '{1'b0, 32'h20,   2'd2, 1'b0, 32'h0,        32'h11AB3344, 1'b0, 4'h0,    32'h0};
    vecs[7]  = '{1'b1, 32'h26,   2'd1, 1'b0, 32'hCAFEBEEF, 32'h0,        1'b0, 4'b1100, 32'hBEEFBEEF};
    vecs[8]  = '{1'b0, 32'h26,   2'd1, 1'b0, 32'h0,        32'hFFFFBEEF, 1'b0, 4'h0,    32'h0};
    vecs[9]  = '{1'b0, 32'h6,    2'd2, 1'b0, 32'h0,        32'h0,        1'b1, 4'h0,    32'h0};
    vecs[10] = '{1'b0, 32'h3,    2'd1, 1'b0, 32'h0,        32'h0,        1'b1, 4'h0,    32'h0};
    vecs[11] = '{1'b0, 32'h14,   2'd3, 1'b0, 32'h0,        32'h0,        1'b1, 4'h0,    32'h0};
    vecs[12] = '{1'b1, 32'h1000, 2'd2, 1'b0, 32'h12345678, 32'h0,        1'b1, 4'h0,    32'h0};

    // A valid load offered during reset must not strobe the SRAM.
    bus.req_valid    = 1'b1;
    bus.req_write    = 1'b0;
    bus.req_addr     = 32'h14;
    bus.req_size     = 2'd2;
    bus.req_unsigned = 1'b0;
    bus.req_wdata    = 32'd0;
    bus.resp_ready   = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_rd_strobe", bus.sram_read_req, 0);
    check("rst_wr_strobe", bus.sram_write_req, 0);
    check("rst_resp_valid", bus.resp_valid, 0);
    bus.req_valid = 1'b0;
    reset   = 1'b0;
    preload = 1'b0;
    @(negedge clk);
    check("rst_req_ready", bus.req_ready, 1);
    check("rst_resp_err", bus.resp_err, 0);
    check("rst_resp_rdata", bus.resp_rdata, 0);
    check("rst_resp_valid2", bus.resp_valid, 0);

    for (int i = 0; i < 13; i++) begin
      do_txn(vecs[i].wr, vecs[i].addr, vecs[i].size, vecs[i].uns, vecs[i].wdata, 0,
             rdata, err, lat, rd_stb, wr_stb, be, wd);
      check($sformatf("v%0d_rdata", i), rdata, vecs[i].exp_rdata);
      check($sformatf("v%0d_err", i), err, vecs[i].exp_err);
      check($sformatf("v%0d_latency", i), lat, (vecs[i].exp_err || vecs[i].wr) ? 1 : 2);
      check($sformatf("v%0d_rd_strobe", i), rd_stb, !vecs[i].exp_err && !vecs[i].wr);
      check($sformatf("v%0d_wr_strobe", i), wr_stb, !vecs[i].exp_err && vecs[i].wr);
      if (vecs[i].wr && !vecs[i].exp_err) begin
        check($sformatf("v%0d_byte_en", i), be, vecs[i].exp_be);
        check($sformatf("v%0d_wdata", i), wd, vecs[i].exp_wd);
      end
    end

    // Backpressure: response held for 5 cycles, then the next load follows immediately.
    do_txn(1'b0, 32'h17, 2'd0, 1'b0, 32'd0, 5, rdata, err, lat, rd_stb, wr_stb, be, wd);
    check("hold_load_rdata", rdata, 32'hFFFFFF80);
    check("hold_load_latency", lat, 2);
    do_txn(1'b0, 32'h20, 2'd2, 1'b0, 32'd0, 0, rdata, err, lat, rd_stb, wr_stb, be, wd);
    check("post_hold_word8", rdata, 32'h11AB3344);

    // Reset while waiting on SRAM read data drops the load.
    bus.req_valid    = 1'b1;
    bus.req_write    = 1'b0;
    bus.req_addr     = 32'h17;
    bus.req_size     = 2'd0;
    bus.req_unsigned = 1'b0;
    check("midrst_ready", bus.req_ready, 1);
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    check("midrst_in_capt", bus.req_ready, 0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst_resp_valid", bus.resp_valid, 0);
    check("midrst_req_ready", bus.req_ready, 1);
    repeat (2) @(negedge clk);
    check("midrst_no_resp", bus.resp_valid, 0);
    $display("txn reset during RD_CAPT, resp_valid=%0d req_ready=%0d", bus.resp_valid, bus.req_ready);
    do_txn(1'b0, 32'h14, 2'd2, 1'b0, 32'd0, 0, rdata, err, lat, rd_stb, wr_stb, be, wd);
    check("after_rst_rdata", rdata, 32'h80FF7F01);
    check("after_rst_err", err, 0);
    check("after_rst_latency", lat, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
